frame_accumulator: RTL
======================

Name: frame_accumulator

Overview:
- Sequential successor to the combinational ripple adder.
- Sums a frame of COUNT input samples, signed or unsigned, into an OUT_WIDTH result.
- Provides a per-frame sticky overflow flag and valid/ready handshakes on both sides.
- Sits between the sample front-end and the decision-tree feature stage, producing windowed sums (energy or area features) per spike frame.

Parameters:
- IN_WIDTH, 8, width of each input sample.
- OUT_WIDTH, 12, width of the result. Must be >= IN_WIDTH.
- COUNT, 4, samples per frame. Must be >= 1.
- SIGNED, 1'b1, 1 = two's-complement operands/result; 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame abort: discards the partial sum and any held result.
- in_data  input  IN_WIDTH  sample.
- in_valid  input  1  sample present.
- in_ready  output  1  block accepts a sample this cycle.
- out_sum  output  OUT_WIDTH  frame sum.
- out_v  output  1  overflow occurred in this frame.
- out_valid  output  1  out_sum/out_v valid.
- out_ready  input  1  consumer takes the result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (and clear) values: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_v=0, in_ready=1 (combinational from state).
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at a rising edge.
- On accept in ACCUM:
  - Extend in_data to OUT_WIDTH+1 bits: sign-extend if SIGNED, zero-extend otherwise.
  - Add it to acc, also extended, forming next.
  - acc <= next[OUT_WIDTH-1:0], i.e. wraps.
  - ovf <= ovf | out_of_range(next).
- out_of_range:
  - SIGNED: next[OUT_WIDTH] != next[OUT_WIDTH-1].
  - Unsigned: next[OUT_WIDTH]=1.
- Counter: cnt increments on each accept.
- Frame completion, on the accept with cnt==COUNT-1:
  - out_sum <= new acc, out_v <= new ovf.
  - Go to HOLD. out_valid=1 the cycle after the last sample is accepted (latency 1).
  - Reset acc, cnt and ovf to 0.
- In HOLD:
  - out_sum and out_v are stable while out_valid & !out_ready.
  - On out_ready, return to ACCUM next cycle. in_ready=1 from that cycle.
  - There is no bypass: one bubble cycle per frame.
- COUNT=1: every accepted sample produces a result; out_v=0 always, since OUT_WIDTH >= IN_WIDTH.
- clear is asserted:
  - It has priority over any accept or out_ready in the same cycle.
  - Next cycle: ACCUM, acc=cnt=ovf=0, out_valid=0.
  - A held, unconsumed result is dropped.
- reset has priority over clear.
- in_valid while in HOLD: the sample is not accepted (in_ready=0). The producer must hold it.
- Accumulator register is OUT_WIDTH bits. The overflow detector uses only the extra bit of next; there is no wider internal state.

Optional Feature:
- Macro: FRAME_ACCUMULATOR_SATURATE_EN.
- Defined:
  - On each accept where out_of_range(next), acc clamps instead of wrapping.
  - Clamp targets: SIGNED gives max 2^(OUT_WIDTH-1)-1 or min -2^(OUT_WIDTH-1) by the sign of next[OUT_WIDTH]; unsigned gives 2^OUT_WIDTH-1.
  - Later samples add to the clamped value.
  - out_v is still set (sticky).
- Undefined: two's-complement wrap as specified above; no saturation logic synthesised.

Test Plan:
1. SIGNED=0, COUNT=4, OUT_WIDTH=12; samples 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_sum=10, out_v=0; in_ready low exactly one cycle.
2. SIGNED=1, IN_WIDTH=8, OUT_WIDTH=8, COUNT=2; samples 100,100 -> out_sum=-56 (0xC8), out_v=1. With SATURATE_EN -> out_sum=127, out_v=1. Next frame 1,1 -> out_sum=2, out_v=0 (sticky clears per frame).
3. SIGNED=1 defaults; samples -128,-128,-128,-128 -> out_sum=-512 (0xE00), out_v=0. Then 127 x4 -> 508, out_v=0.
4. Backpressure: complete a frame with out_ready=0 for 5 cycles -> out_valid, out_sum and out_v stable; in_ready=0; in_valid pulses are ignored (next frame sum excludes them); release out_ready -> in_ready=1 the following cycle.
5. clear after 2 of 4 samples (5,6), then feed 1,1,1,1 -> out_sum=4. clear coincident with the 4th accept -> no out_valid. clear in HOLD -> result dropped, out_valid=0 next cycle.
6. reset asserted mid-frame and in HOLD -> all outputs at reset values next cycle; reset with clear and in_valid high simultaneously -> reset state, sample not counted.

Source files
------------

// File: rtl/frame_accumulator.sv
// ---------------------------------------------------------------------------
// frame_accumulator
//
// Sums a frame of COUNT samples (signed or unsigned) into an OUT_WIDTH
// result. Each frame also gets a sticky overflow flag. Both sides use
// valid/ready handshakes. The block sits between the sample front-end and
// the decision-tree feature stage and produces one windowed sum per frame.
//
// Parameters:
//   IN_WIDTH  - width of each input sample
//   OUT_WIDTH - width of the result and of the accumulator (>= IN_WIDTH)
//   COUNT     - samples per frame (>= 1)
//   SIGNED    - 1: two's-complement operands/result, 0: unsigned
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high reset
//   clear     - synchronous frame abort: drops the partial sum and any held result
//   in_data   - input sample
//   in_valid  - a sample is present on in_data
//   in_ready  - the block accepts a sample this cycle
//   out_sum   - frame sum
//   out_v     - overflow occurred somewhere in this frame
//   out_valid - out_sum/out_v are valid
//   out_ready - the consumer takes the result
//
// Optional feature (compile-time macro FRAME_ACCUMULATOR_SATURATE_EN):
//   When the macro is defined, the accumulator clamps to the representable
//   range on overflow instead of wrapping. The sticky overflow flag is still
//   reported. When the macro is undefined, no clamp logic is built.
// ---------------------------------------------------------------------------
module frame_accumulator #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 12,
    parameter int COUNT     = 4,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_sum,
    output logic                 out_v,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // The counter is kept at least one bit wide so that COUNT=1 still elaborates.
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
    localparam int EXT_W = OUT_WIDTH + 1 - IN_WIDTH;

`ifdef FRAME_ACCUMULATOR_SATURATE_EN
    localparam logic [OUT_WIDTH-1:0] SAT_HI = SIGNED ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                                                     : {OUT_WIDTH{1'b1}};
    localparam logic [OUT_WIDTH-1:0] SAT_LO = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`endif

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t               state;
    logic [OUT_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf;

    logic [OUT_WIDTH:0]   in_ext;
    logic [OUT_WIDTH:0]   acc_ext;
    logic [OUT_WIDTH:0]   next;
    logic                 out_of_range;
    logic [OUT_WIDTH-1:0] acc_new;
    logic                 ovf_new;
    logic                 accept;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;

    // Add with one guard bit. Outside the range of the result, the guard bit
    // disagrees with the result MSB (signed) or is set (unsigned).
    always_comb begin
        in_ext  = SIGNED ? {{EXT_W{in_data[IN_WIDTH-1]}}, in_data}
                         : {{EXT_W{1'b0}}, in_data};
        acc_ext = SIGNED ? {acc[OUT_WIDTH-1], acc} : {1'b0, acc};
        next    = in_ext + acc_ext;
        out_of_range = SIGNED ? (next[OUT_WIDTH] != next[OUT_WIDTH-1])
                              : next[OUT_WIDTH];
        ovf_new = ovf | out_of_range;
`ifdef FRAME_ACCUMULATOR_SATURATE_EN
        // A signed guard bit of 1 means the true sum fell below the minimum.
        if (!out_of_range) begin
            acc_new = next[OUT_WIDTH-1:0];
        end else if (SIGNED && next[OUT_WIDTH]) begin
            acc_new = SAT_LO;
        end else begin
            acc_new = SAT_HI;
        end
`else
        acc_new = next[OUT_WIDTH-1:0];
`endif
    end

    // The frame FSM. Reset and clear leave the block in the same state, so
    // they share one branch. The last accepted sample of a frame loads the
    // result registers directly. This gives a latency of one cycle. The
    // running state returns to zero for the next frame at the same time.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_v     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            out_sum   <= acc_new;
                            out_v     <= ovf_new;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc <= acc_new;
                            cnt <= cnt + CNT_W'(1);
                            ovf <= ovf_new;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule
